seg14_capture: RTL and testbench

//  Inverse of the BCD-to-14-segment path: samples a time-multiplexed, active-low 14-segment display bus
//  (15-bit pattern + active-low one-hot digit select), waits for each digit's pattern to be stable,

---
 rtl/seg14_pkg.sv | 56 +++++
 rtl/seg14_capture_if.sv | 33 +++
 rtl/seg14_lut.sv | 35 +++
 rtl/seg14_capture.sv | 189 ++++++++++++++++++
 tb/tb_seg14_capture.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg14_pkg.sv
// seg14_pkg: shared constants and types for the 14-segment capture monitor.
//   SEG_W        width of the segment bus (14 segments + decimal point)
//   PAT_*        active-low segment patterns recognised by the decoder
//   CODE_BLANK   code reported for an all-off (blank) digit
//   state_e      stabilisation FSM states
//   onehot_idx   active-low digit select -> {valid, index}
package seg14_pkg;

    localparam int unsigned SEG_W = 15;

    localparam logic [SEG_W-1:0] PAT_0     = 15'h01FF;
    localparam logic [SEG_W-1:0] PAT_1     = 15'h7FDB;
    localparam logic [SEG_W-1:0] PAT_2     = 15'h127F;
    localparam logic [SEG_W-1:0] PAT_3     = 15'h067F;
    localparam logic [SEG_W-1:0] PAT_4     = 15'h4C7F;
    localparam logic [SEG_W-1:0] PAT_5     = 15'h247F;
    localparam logic [SEG_W-1:0] PAT_6     = 15'h207F;
    localparam logic [SEG_W-1:0] PAT_7     = 15'h0FFF;
    localparam logic [SEG_W-1:0] PAT_8     = 15'h007F;
    localparam logic [SEG_W-1:0] PAT_9     = 15'h047F;
    localparam logic [SEG_W-1:0] PAT_A     = 15'h087F;
    localparam logic [SEG_W-1:0] PAT_P     = 15'h187F;
    localparam logic [SEG_W-1:0] PAT_M     = 15'h49AF;
    localparam logic [SEG_W-1:0] PAT_BLANK = 15'h7FFF;

    localparam logic [3:0] CODE_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        HELD
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } sel_t;

    // Select is padded to 8 bits with inactive (high) lines by the caller.
    function automatic sel_t onehot_idx(input logic [7:0] sel_n);
        sel_t        r;
        int unsigned lows;
        r.valid = 1'b0;
        r.idx   = 3'd0;
        lows    = 0;
        for (int i = 0; i < 8; i++) begin
            if (!sel_n[i]) begin
                lows++;
                r.idx = 3'(i);
            end
        end
        r.valid = (lows == 1);
        return r;
    endfunction

endpackage

// File: rtl/seg14_capture_if.sv
// seg14_capture_if: display bus and result signals of the capture monitor.
//   seg_in, dig_sel, err_clr          display bus / control into the monitor
//   bcd_out, digit_valid              committed codes and per-digit valid
//   upd_pulse, upd_idx                commit strobe and digit index
//   err_pulse, err_flag, err_cnt      illegal-pattern strobe, sticky flag, count
// Modports: master drives the bus (display side / bench), slave is the monitor.
interface seg14_capture_if #(
    parameter int unsigned DIGITS = 4
);
    import seg14_pkg::*;

    logic [SEG_W-1:0]    seg_in;
    logic [DIGITS-1:0]   dig_sel;
    logic                err_clr;
    logic [4*DIGITS-1:0] bcd_out;
    logic [DIGITS-1:0]   digit_valid;
    logic                upd_pulse;
    logic [2:0]          upd_idx;
    logic                err_pulse;
    logic                err_flag;
    logic [7:0]          err_cnt;

    modport master (
        output seg_in, dig_sel, err_clr,
        input  bcd_out, digit_valid, upd_pulse, upd_idx, err_pulse, err_flag, err_cnt
    );

    modport slave (
        input  seg_in, dig_sel, err_clr,
        output bcd_out, digit_valid, upd_pulse, upd_idx, err_pulse, err_flag, err_cnt
    );

endinterface

// File: rtl/seg14_lut.sv
// seg14_lut: combinational reverse decoder, 14-segment pattern -> 4-bit code.
//   pattern  in   active-low segment pattern
//   legal    out  1 when the pattern is in the table (blank counts as legal)
//   code     out  decoded code, CODE_BLANK when illegal
module seg14_lut
    import seg14_pkg::*;
(
    input  logic [SEG_W-1:0] pattern,
    output logic             legal,
    output logic [3:0]       code
);

    always_comb begin
        legal = 1'b1;
        code  = CODE_BLANK;
        case (pattern)
            PAT_0:     code = 4'd0;
            PAT_1:     code = 4'd1;
            PAT_2:     code = 4'd2;
            PAT_3:     code = 4'd3;
            PAT_4:     code = 4'd4;
            PAT_5:     code = 4'd5;
            PAT_6:     code = 4'd6;
            PAT_7:     code = 4'd7;
            PAT_8:     code = 4'd8;
            PAT_9:     code = 4'd9;
            PAT_A:     code = 4'd10;
            PAT_P:     code = 4'd11;
            PAT_M:     code = 4'd12;
            PAT_BLANK: code = CODE_BLANK;
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg14_capture.sv
// seg14_capture: loopback monitor for a multiplexed active-low 14-segment display.
// Samples the bus, waits until a digit's pattern has been stable for STABLE_CYCLES
// samples, decodes it and stores one code per digit.
//   clk, rst_n   clock and asynchronous active-low reset
//   bus          seg14_capture_if.slave (display bus in, codes/strobes/errors out)
// Parameters: DIGITS (2..8), STABLE_CYCLES (2..255).
// Build option: define SEG14_ERRCNT_EN to enable the saturating err_cnt counter;
// otherwise err_cnt reads 8'h00.
module seg14_capture
    import seg14_pkg::*;
#(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input logic           clk,
    input logic           rst_n,
    seg14_capture_if.slave bus
);

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    // Input sample (s_q) and its previous value (s_p).
    logic [SEG_W-1:0]  seg_q, seg_p;
    logic [DIGITS-1:0] dig_q, dig_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= '1;
            seg_p <= '1;
            dig_q <= '1;
            dig_p <= '1;
        end else begin
            seg_q <= bus.seg_in;
            seg_p <= seg_q;
            dig_q <= bus.dig_sel;
            dig_p <= dig_q;
        end
    end

    logic       changed;
    logic [7:0] sel_pad;
    sel_t       sel;

    assign changed = (seg_q != seg_p) || (dig_q != dig_p);

    always_comb begin
        sel_pad               = '1;
        sel_pad[DIGITS-1:0]   = dig_q;
    end

    assign sel = onehot_idx(sel_pad);

    logic       lut_legal;
    logic [3:0] lut_code;

    seg14_lut u_lut (
        .pattern (seg_q),
        .legal   (lut_legal),
        .code    (lut_code)
    );

    // Stabilisation FSM: state register.
    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. cnt counts identical samples seen so far for the current pattern.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (sel.valid) begin
                    state_d = COUNT;
                    cnt_d   = 8'd1;
                end
            end
            COUNT: begin
                if (changed) begin
                    cnt_d   = 8'd1;
                    state_d = sel.valid ? COUNT : IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HELD: begin
                if (changed) begin
                    cnt_d   = 8'd1;
                    state_d = sel.valid ? COUNT : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Output logic: commit decision and next values of the result registers.
    logic                commit, commit_ok, commit_bad;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [DIGITS-1:0]   valid_q, valid_d;
    logic                err_flag_q, err_flag_d;

    always_comb begin
        commit     = (state_q == COUNT) && !changed && (cnt_q == CNT_LAST);
        commit_ok  = commit && lut_legal;
        commit_bad = commit && !lut_legal;
        bcd_d      = bcd_q;
        valid_d    = valid_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (commit_ok && (sel.idx == 3'(i))) begin
                bcd_d[4*i +: 4] = lut_code;
                valid_d[i]      = 1'b1;
            end
        end
        // Set has priority over a simultaneous clear.
        err_flag_d = commit_bad ? 1'b1 : (bus.err_clr ? 1'b0 : err_flag_q);
    end

    logic       upd_pulse_q, err_pulse_q;
    logic [2:0] upd_idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q       <= '1;
            valid_q     <= '0;
            upd_pulse_q <= 1'b0;
            upd_idx_q   <= 3'd0;
            err_pulse_q <= 1'b0;
            err_flag_q  <= 1'b0;
        end else begin
            bcd_q       <= bcd_d;
            valid_q     <= valid_d;
            upd_pulse_q <= commit_ok;
            err_pulse_q <= commit_bad;
            err_flag_q  <= err_flag_d;
            if (commit_ok) begin
                upd_idx_q <= sel.idx;
            end
        end
    end

`ifdef SEG14_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Clear first, then count, so a clear coinciding with an error leaves 1.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (bus.err_clr) begin
            err_cnt_d = 8'h00;
        end
        if (commit_bad && (err_cnt_d != 8'hFF)) begin
            err_cnt_d = err_cnt_d + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'h00;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.err_cnt = 8'h00;
`endif

    assign bus.bcd_out     = bcd_q;
    assign bus.digit_valid = valid_q;
    assign bus.upd_pulse   = upd_pulse_q;
    assign bus.upd_idx     = upd_idx_q;
    assign bus.err_pulse   = err_pulse_q;
    assign bus.err_flag    = err_flag_q;

endmodule

// File: tb/tb_seg14_capture.sv
// tb_seg14_capture: self-checking bench for seg14_capture (DIGITS=4, STABLE_CYCLES=4).
// Reference model: a digit is committed on the edge after its sample has been seen
// STABLE_CYCLES times in a row with exactly one select line low.
module tb_seg14_capture;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned STABLE = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    seg14_capture_if #(.DIGITS(DIGITS)) bus ();

    seg14_capture #(
        .DIGITS        (DIGITS),
        .STABLE_CYCLES (STABLE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [14:0] pat_tab  [14] = '{15'h01FF, 15'h7FDB, 15'h127F, 15'h067F, 15'h4C7F, 15'h247F,
                                   15'h207F, 15'h0FFF, 15'h007F, 15'h047F, 15'h087F, 15'h187F,
                                   15'h49AF, 15'h7FFF};
    logic [3:0]  code_tab [14] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9,
                                   4'hA, 4'hB, 4'hC, 4'hF};

    // Model state
    logic [14:0]       m_prev_seg;
    logic [3:0]        m_prev_dig;
    int                m_run;
    logic [3:0]        m_bcd [DIGITS];
    logic [DIGITS-1:0] m_valid;
    logic              m_flag;
    int                m_cnt;
    int                m_upd_total = 0;
    int                m_err_total = 0;
    int                m_last_idx  = 0;

    // Observed DUT strobes
    int d_upd_total = 0;
    int d_err_total = 0;
    int d_last_idx  = 0;

    function automatic bit ref_decode(input logic [14:0] p, output logic [3:0] c);
        c = 4'hF;
        for (int i = 0; i < 14; i++) begin
            if (pat_tab[i] == p) begin
                c = code_tab[i];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic logic [15:0] m_bcd_packed();
        logic [15:0] r;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = m_bcd[i];
        return r;
    endfunction

    function automatic logic [7:0] m_exp_cnt();
`ifdef SEG14_ERRCNT_EN
        return 8'(m_cnt);
`else
        return 8'h00;
`endif
    endfunction

    task automatic m_reset();
        m_prev_seg = 15'h7FFF;
        m_prev_dig = 4'hF;
        m_run      = 1;
        for (int i = 0; i < 4; i++) m_bcd[i] = 4'hF;
        m_valid = '0;
        m_flag  = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic model_edge(input logic [14:0] s, input logic [3:0] d, input logic clr);
        bit         commit;
        bit         legal;
        logic [3:0] c;
        int         idx;
        legal  = 1'b0;
        idx    = 0;
        commit = (m_run == STABLE) && ($countones(~m_prev_dig) == 1);
        if (commit) begin
            legal = ref_decode(m_prev_seg, c);
            for (int i = 0; i < 4; i++) if (!m_prev_dig[i]) idx = i;
            if (legal) begin
                m_bcd[idx]   = c;
                m_valid[idx] = 1'b1;
                m_upd_total++;
                m_last_idx = idx;
            end else begin
                m_err_total++;
            end
        end
        if (commit && !legal) m_flag = 1'b1;
        else if (clr)         m_flag = 1'b0;
        if (clr) m_cnt = 0;
        if (commit && !legal && m_cnt < 255) m_cnt++;
        if (s == m_prev_seg && d == m_prev_dig) m_run++;
        else m_run = 1;
        m_prev_seg = s;
        m_prev_dig = d;
    endtask

    task automatic tick();
        logic [14:0] s;
        logic [3:0]  d;
        logic        clr;
        s   = bus.seg_in;
        d   = bus.dig_sel;
        clr = bus.err_clr;
        @(posedge clk);
        model_edge(s, d, clr);
        #1;
        if (bus.upd_pulse === 1'b1) begin
            d_upd_total++;
            d_last_idx = int'(bus.upd_idx);
        end
        if (bus.err_pulse === 1'b1) d_err_total++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        bus.seg_in  = 15'h7FFF;
        bus.dig_sel = 4'hF;
        bus.err_clr = 1'b0;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.bcd_out !== 16'hFFFF) begin errors++;
            $display("FAIL reset_bcd: got %h expected ffff", bus.bcd_out); end
        checks++; if (bus.digit_valid !== 4'h0) begin errors++;
            $display("FAIL reset_valid: got %b expected 0000", bus.digit_valid); end
        checks++; if ({bus.upd_pulse, bus.err_pulse, bus.err_flag, bus.upd_idx} !== 6'b0) begin
            errors++; $display("FAIL reset_strobes: got %b expected 000000",
                {bus.upd_pulse, bus.err_pulse, bus.err_flag, bus.upd_idx}); end
        checks++; if (bus.err_cnt !== 8'h00) begin errors++;
            $display("FAIL reset_errcnt: got %h expected 00", bus.err_cnt); end
        rst_n = 1'b1;
        m_reset();
    endtask

    task automatic test_legal_commit();
        int base;
        base        = d_upd_total;
        bus.dig_sel = 4'b1101;
        bus.seg_in  = 15'h067F;
        ticks(4);
        checks++; if (d_upd_total != base) begin errors++;
            $display("FAIL legal_early: got %0d commits expected 0", d_upd_total - base); end
        tick();
        checks++; if (bus.upd_pulse !== 1'b1 || bus.upd_idx !== 3'd1) begin errors++;
            $display("FAIL legal_pulse: got pulse=%b idx=%0d expected pulse=1 idx=1",
                bus.upd_pulse, bus.upd_idx); end
        checks++; if (bus.bcd_out[7:4] !== 4'h3 || bus.bcd_out !== m_bcd_packed()) begin errors++;
            $display("FAIL legal_bcd: got %h expected %h (digit1=3)", bus.bcd_out, m_bcd_packed()); end
        checks++; if (bus.digit_valid !== 4'b0010) begin errors++;
            $display("FAIL legal_valid: got %b expected 0010", bus.digit_valid); end
        ticks(20);
        checks++; if (d_upd_total != base + 1 || m_upd_total != d_upd_total) begin errors++;
            $display("FAIL legal_hold: got %0d commits expected 1", d_upd_total - base); end
    endtask

    task automatic test_glitch();
        int base;
        base        = d_upd_total;
        bus.dig_sel = 4'b1110;
        bus.seg_in  = 15'h01FF;
        ticks(3);
        bus.seg_in  = 15'h007F;
        tick();
        bus.seg_in  = 15'h01FF;
        ticks(4);
        checks++; if (d_upd_total != base || bus.bcd_out[3:0] !== 4'hF) begin errors++;
            $display("FAIL glitch_reject: got commits=%0d bcd0=%h expected 0 f",
                d_upd_total - base, bus.bcd_out[3:0]); end
        tick();
        checks++; if (bus.upd_pulse !== 1'b1 || bus.bcd_out[3:0] !== 4'h0) begin errors++;
            $display("FAIL glitch_commit: got pulse=%b bcd0=%h expected 1 0",
                bus.upd_pulse, bus.bcd_out[3:0]); end
    endtask

    task automatic test_illegal();
        bus.dig_sel = 4'b1011;
        bus.seg_in  = 15'h1234;
        ticks(5);
        checks++; if (bus.err_pulse !== 1'b1 || bus.err_flag !== 1'b1) begin errors++;
            $display("FAIL illegal_err: got pulse=%b flag=%b expected 1 1",
                bus.err_pulse, bus.err_flag); end
        checks++; if (bus.bcd_out[11:8] !== 4'hF || bus.digit_valid[2] !== 1'b0) begin errors++;
            $display("FAIL illegal_nochange: got bcd2=%h valid2=%b expected f 0",
                bus.bcd_out[11:8], bus.digit_valid[2]); end
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        checks++; if (bus.err_flag !== 1'b0 || bus.err_cnt !== 8'h00) begin errors++;
            $display("FAIL illegal_clear: got flag=%b cnt=%h expected 0 00",
                bus.err_flag, bus.err_cnt); end
        bus.seg_in = 15'h1235;
        ticks(4);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        checks++; if (bus.err_pulse !== 1'b1 || bus.err_flag !== 1'b1) begin errors++;
            $display("FAIL illegal_setwins: got pulse=%b flag=%b expected 1 1",
                bus.err_pulse, bus.err_flag); end
        checks++; if (bus.err_cnt !== m_exp_cnt()) begin errors++;
            $display("FAIL illegal_cnt: got %h expected %h", bus.err_cnt, m_exp_cnt()); end
    endtask

    task automatic test_select_rules();
        int bu, be;
        bu          = d_upd_total;
        be          = d_err_total;
        bus.seg_in  = 15'h127F;
        bus.dig_sel = 4'b1111;
        ticks(10);
        bus.dig_sel = 4'b0011;
        ticks(10);
        checks++; if (d_upd_total != bu || d_err_total != be) begin errors++;
            $display("FAIL select_rules: got commits=%0d errs=%0d expected 0 0",
                d_upd_total - bu, d_err_total - be); end
    endtask

    task automatic test_full_scan();
        logic [14:0] msg [4];
        msg[3] = 15'h7FDB;
        msg[2] = 15'h127F;
        msg[1] = 15'h087F;
        msg[0] = 15'h49AF;
        for (int r = 0; r < 2; r++) begin
            for (int d = 3; d >= 0; d--) begin
                bus.dig_sel = ~(4'b0001 << d);
                bus.seg_in  = msg[d];
                ticks(8);
            end
        end
        checks++; if (bus.bcd_out !== 16'h12AC) begin errors++;
            $display("FAIL scan_bcd: got %h expected 12ac", bus.bcd_out); end
        checks++; if (bus.digit_valid !== 4'hF || d_last_idx != 0) begin errors++;
            $display("FAIL scan_valid: got %b last_idx=%0d expected 1111 0",
                bus.digit_valid, d_last_idx); end
    endtask

    task automatic test_random();
        int hold;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) < 8) bus.dig_sel = ~(4'b0001 << $urandom_range(0, 3));
            else                          bus.dig_sel = 4'($urandom);
            if ($urandom_range(0, 3) == 0) bus.seg_in = 15'($urandom);
            else                           bus.seg_in = pat_tab[$urandom_range(0, 13)];
            hold = int'($urandom_range(1, 7));
            for (int c = 0; c < hold; c++) begin
                bus.err_clr = ($urandom_range(0, 7) == 0);
                tick();
            end
            bus.err_clr = 1'b0;
            checks++; if (bus.bcd_out !== m_bcd_packed() || bus.digit_valid !== m_valid) begin
                errors++; $display("FAIL rand_codes[%0d]: got %h/%b expected %h/%b", n,
                    bus.bcd_out, bus.digit_valid, m_bcd_packed(), m_valid); end
            checks++; if (bus.err_flag !== m_flag || bus.err_cnt !== m_exp_cnt()) begin
                errors++; $display("FAIL rand_err[%0d]: got flag=%b cnt=%h expected %b %h", n,
                    bus.err_flag, bus.err_cnt, m_flag, m_exp_cnt()); end
            checks++; if (d_upd_total != m_upd_total || d_err_total != m_err_total) begin
                errors++; $display("FAIL rand_strobes[%0d]: got upd=%0d err=%0d expected %0d %0d",
                    n, d_upd_total, d_err_total, m_upd_total, m_err_total); end
        end
        checks++; if (d_last_idx != m_last_idx) begin errors++;
            $display("FAIL rand_idx: got %0d expected %0d", d_last_idx, m_last_idx); end
    endtask

    task automatic test_reset_mid_count();
        int base;
        bus.err_clr = 1'b0;
        bus.dig_sel = 4'b0111;
        bus.seg_in  = 15'h0FFF;
        ticks(2);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.bcd_out !== 16'hFFFF || bus.digit_valid !== 4'h0) begin errors++;
            $display("FAIL midreset_outputs: got %h/%b expected ffff/0000",
                bus.bcd_out, bus.digit_valid); end
        checks++; if ({bus.upd_pulse, bus.err_pulse, bus.err_flag, bus.err_cnt} !== 11'b0) begin
            errors++; $display("FAIL midreset_err: got %b expected 0",
                {bus.upd_pulse, bus.err_pulse, bus.err_flag, bus.err_cnt}); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_reset();
        base = d_upd_total;
        ticks(4);
        checks++; if (d_upd_total != base) begin errors++;
            $display("FAIL midreset_discard: got %0d commits expected 0", d_upd_total - base); end
        tick();
        checks++; if (bus.upd_pulse !== 1'b1 || bus.bcd_out !== 16'h7FFF) begin errors++;
            $display("FAIL midreset_recommit: got pulse=%b bcd=%h expected 1 7fff",
                bus.upd_pulse, bus.bcd_out); end
    endtask

    task automatic test_err_count();
        bus.err_clr = 1'b1;
        bus.dig_sel = 4'b1110;
        tick();
        bus.err_clr = 1'b0;
        for (int n = 0; n < 300; n++) begin
            bus.seg_in = (n % 2 == 0) ? 15'h1234 : 15'h1235;
            ticks(5);
        end
`ifdef SEG14_ERRCNT_EN
        checks++; if (bus.err_cnt !== 8'hFF || m_exp_cnt() !== 8'hFF) begin errors++;
            $display("FAIL errcnt_sat: got %h expected ff", bus.err_cnt); end
`else
        checks++; if (bus.err_cnt !== 8'h00) begin errors++;
            $display("FAIL errcnt_tied: got %h expected 00", bus.err_cnt); end
`endif
        checks++; if (d_err_total != m_err_total || bus.err_flag !== 1'b1) begin errors++;
            $display("FAIL errcnt_pulses: got %0d flag=%b expected %0d 1",
                d_err_total, bus.err_flag, m_err_total); end
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        checks++; if (bus.err_cnt !== 8'h00 || bus.err_flag !== 1'b0) begin errors++;
            $display("FAIL errcnt_clear: got cnt=%h flag=%b expected 00 0",
                bus.err_cnt, bus.err_flag); end
    endtask

    initial begin
        test_reset();
        test_legal_commit();
        test_glitch();
        test_illegal();
        test_select_rules();
        test_full_scan();
        test_random();
        test_reset_mid_count();
        test_err_count();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
